// File: rtl/kbd_set1_fifo_pkg.sv
// Shared constants, FSM state type and push payload for the set-2 to set-1 keyboard FIFO.
package kbd_set1_fifo_pkg;

  localparam logic [7:0] S2_EXT0       = 8'hE0;
  localparam logic [7:0] S2_EXT1       = 8'hE1;
  localparam logic [7:0] S2_BREAK      = 8'hF0;
  localparam logic [7:0] S2_ACK        = 8'hFA;
  localparam logic [7:0] S2_BAT_OK     = 8'hAA;
  localparam logic [7:0] S2_ECHO       = 8'hEE;
  localparam logic [7:0] S2_RESEND     = 8'hFE;
  localparam logic [7:0] S2_OVR_LO     = 8'h00;
  localparam logic [7:0] S2_OVR_HI     = 8'hFF;
  localparam logic [7:0] S2_MAX_CODE   = 8'h83;
  localparam logic [7:0] S1_BREAK_MASK = 8'h80;
  localparam logic [7:0] S1_OVERRUN    = 8'hFF;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BREAK = 1'b1
  } kbd_state_e;

  typedef struct packed {
    logic       valid;
    logic [7:0] code;
  } kbd_push_t;

endpackage

// File: rtl/kbd_set2to1.sv
// Combinational set-2 make code to set-1 make code lookup; 0x00 marks an unmapped code.
module kbd_set2to1
  import kbd_set1_fifo_pkg::*;
(
  input  logic [7:0] set2_i,
  output logic [7:0] set1_o
);

  always_comb begin
    set1_o = 8'h00;
    case (set2_i)
      8'h01: set1_o = 8'h43;  8'h03: set1_o = 8'h3F;  8'h04: set1_o = 8'h3D;
      8'h05: set1_o = 8'h3B;  8'h06: set1_o = 8'h3C;  8'h07: set1_o = 8'h58;
      8'h09: set1_o = 8'h44;  8'h0A: set1_o = 8'h42;  8'h0B: set1_o = 8'h40;
      8'h0C: set1_o = 8'h3E;  8'h0D: set1_o = 8'h0F;  8'h0E: set1_o = 8'h29;
      8'h11: set1_o = 8'h38;  8'h12: set1_o = 8'h2A;  8'h14: set1_o = 8'h1D;
      8'h15: set1_o = 8'h10;  8'h16: set1_o = 8'h02;  8'h1A: set1_o = 8'h2C;
      8'h1B: set1_o = 8'h1F;  8'h1C: set1_o = 8'h1E;  8'h1D: set1_o = 8'h11;
      8'h1E: set1_o = 8'h03;  8'h21: set1_o = 8'h2E;  8'h22: set1_o = 8'h2D;
      8'h23: set1_o = 8'h20;  8'h24: set1_o = 8'h12;  8'h25: set1_o = 8'h05;
      8'h26: set1_o = 8'h04;  8'h29: set1_o = 8'h39;  8'h2A: set1_o = 8'h2F;
      8'h2B: set1_o = 8'h21;  8'h2C: set1_o = 8'h14;  8'h2D: set1_o = 8'h13;
      8'h2E: set1_o = 8'h06;  8'h31: set1_o = 8'h31;  8'h32: set1_o = 8'h30;
      8'h33: set1_o = 8'h23;  8'h34: set1_o = 8'h22;  8'h35: set1_o = 8'h15;
      8'h36: set1_o = 8'h07;  8'h3A: set1_o = 8'h32;  8'h3B: set1_o = 8'h24;
      8'h3C: set1_o = 8'h16;  8'h3D: set1_o = 8'h08;  8'h3E: set1_o = 8'h09;
      8'h41: set1_o = 8'h33;  8'h42: set1_o = 8'h25;  8'h43: set1_o = 8'h17;
      8'h44: set1_o = 8'h18;  8'h45: set1_o = 8'h0B;  8'h46: set1_o = 8'h0A;
      8'h49: set1_o = 8'h34;  8'h4A: set1_o = 8'h35;  8'h4B: set1_o = 8'h26;
      8'h4C: set1_o = 8'h27;  8'h4D: set1_o = 8'h19;  8'h4E: set1_o = 8'h0C;
      8'h52: set1_o = 8'h28;  8'h54: set1_o = 8'h1A;  8'h55: set1_o = 8'h0D;
      8'h58: set1_o = 8'h3A;  8'h59: set1_o = 8'h36;  8'h5A: set1_o = 8'h1C;
      8'h5B: set1_o = 8'h1B;  8'h5D: set1_o = 8'h2B;  8'h61: set1_o = 8'h56;
      8'h66: set1_o = 8'h0E;  8'h69: set1_o = 8'h4F;  8'h6B: set1_o = 8'h4B;
      8'h6C: set1_o = 8'h47;  8'h70: set1_o = 8'h52;  8'h71: set1_o = 8'h53;
      8'h72: set1_o = 8'h50;  8'h73: set1_o = 8'h4C;  8'h74: set1_o = 8'h4D;
      8'h75: set1_o = 8'h48;  8'h76: set1_o = 8'h01;  8'h77: set1_o = 8'h45;
      8'h78: set1_o = 8'h57;  8'h79: set1_o = 8'h4E;  8'h7A: set1_o = 8'h51;
      8'h7B: set1_o = 8'h4A;  8'h7C: set1_o = 8'h37;  8'h7D: set1_o = 8'h49;
      8'h7E: set1_o = 8'h46;  S2_MAX_CODE: set1_o = 8'h41;
      default: set1_o = 8'h00;
    endcase
  end

endmodule

// File: rtl/kbd_set1_fifo.sv
// Translates PS/2 set-2 bytes to set-1 codes and queues them for the port-60h reader.
module kbd_set1_fifo
  import kbd_set1_fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       kbd_done,
  input  logic [7:0]                 kbd_data,
  input  logic                       rd,
  input  logic                       clr,
  output logic [7:0]                 data,
  output logic                       irq,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  kbd_state_e    state_q, state_d;
  kbd_push_t     push_c;
  logic [7:0]    lut_c;
  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    data_q, data_d;
  logic          irq_q, irq_d, overflow_q, overflow_d;
  logic          full_c, pop_c, wr_en_c;

  kbd_set2to1 u_set2to1 (
    .set2_i (kbd_data),
    .set1_o (lut_c)
  );

  // Byte decoder FSM: tracks a pending break prefix and forms at most one push per strobe.
  always_comb begin
    state_d = state_q;
    push_c  = '0;
    if (kbd_done) begin
      if (kbd_data == S2_BREAK) begin
        state_d = ST_BREAK;
      end else if (kbd_data == S2_EXT0 || kbd_data == S2_EXT1) begin
        push_c = '{valid: 1'b1, code: kbd_data};
      end else if (kbd_data == S2_ACK || kbd_data == S2_BAT_OK ||
                   kbd_data == S2_ECHO || kbd_data == S2_RESEND) begin
        push_c  = '{valid: 1'b1, code: kbd_data};
        state_d = ST_IDLE;
      end else if (kbd_data == S2_OVR_LO || kbd_data == S2_OVR_HI) begin
        push_c  = '{valid: 1'b1, code: S1_OVERRUN};
        state_d = ST_IDLE;
      end else begin
        state_d = ST_IDLE;
        if (kbd_data <= S2_MAX_CODE && lut_c != 8'h00) begin
          push_c = '{valid: 1'b1,
                     code: (state_q == ST_BREAK) ? (lut_c | S1_BREAK_MASK) : lut_c};
        end
      end
    end
    if (clr) begin
      state_d = ST_IDLE;
      push_c  = '0;
    end
  end

  // FIFO bookkeeping; a pop frees the slot a same-cycle push needs when full.
  always_comb begin
    full_c     = (count_q == CW'(DEPTH));
    pop_c      = rd && (count_q != '0) && !clr;
    wr_en_c    = push_c.valid && (!full_c || pop_c);
    rd_ptr_d   = pop_c   ? rd_ptr_q + AW'(1) : rd_ptr_q;
    wr_ptr_d   = wr_en_c ? wr_ptr_q + AW'(1) : wr_ptr_q;
    count_d    = count_q;
    if (wr_en_c && !pop_c) count_d = count_q + CW'(1);
    if (!wr_en_c && pop_c) count_d = count_q - CW'(1);
    overflow_d = overflow_q | (push_c.valid && full_c && !pop_c);
    if (clr) begin
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end
    irq_d = (count_d != '0);
    // Head bypass: the new head may be the byte being written this cycle.
    if (count_d == '0)
      data_d = 8'h00;
    else if (wr_en_c && wr_ptr_q == rd_ptr_d)
      data_d = push_c.code;
    else
      data_d = mem_q[rd_ptr_d];
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      irq_q      <= 1'b0;
      data_q     <= 8'h00;
    end else begin
      state_q    <= state_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      irq_q      <= irq_d;
      data_q     <= data_d;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en_c) mem_q[wr_ptr_q] <= push_c.code;
  end

  assign data     = data_q;
  assign irq      = irq_q;
  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_kbd_set1_fifo.sv
// Directed bench for kbd_set1_fifo: translation, ordering, overflow, clear and reset behaviour.
module tb_kbd_set1_fifo;

  localparam int unsigned DEPTH = 16;

  logic       clock = 1'b0;
  logic       reset, kbd_done, rd, clr;
  logic [7:0] kbd_data, data;
  logic       irq, overflow;
  logic [4:0] count;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] exp_seq [6] = '{8'h1E, 8'h9E, 8'hE0, 8'h48, 8'hE0, 8'hC8};

  kbd_set1_fifo #(.DEPTH(DEPTH)) dut (
    .clock    (clock),
    .reset    (reset),
    .kbd_done (kbd_done),
    .kbd_data (kbd_data),
    .rd       (rd),
    .clr      (clr),
    .data     (data),
    .irq      (irq),
    .count    (count),
    .overflow (overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b, input logic with_rd);
    @(negedge clock);
    kbd_data = b;
    kbd_done = 1'b1;
    rd       = with_rd;
    @(negedge clock);
    kbd_done = 1'b0;
    rd       = 1'b0;
  endtask

  task automatic pop();
    @(negedge clock);
    rd = 1'b1;
    @(negedge clock);
    rd = 1'b0;
  endtask

  initial begin
    reset = 1'b1; kbd_done = 1'b0; rd = 1'b0; clr = 1'b0; kbd_data = 8'h00;
    repeat (2) @(negedge clock);
    check("rst_count", 8'(count), 8'd0);
    check("rst_irq", 8'(irq), 8'd0);
    check("rst_ovf", 8'(overflow), 8'd0);
    check("rst_data", data, 8'h00);
    reset = 1'b0;

    // Single make then read
    send(8'h1C, 1'b0);
    check("make_count", 8'(count), 8'd1);
    check("make_irq", 8'(irq), 8'd1);
    check("make_data", data, 8'h1E);
    pop();
    check("pop_count", 8'(count), 8'd0);
    check("pop_irq", 8'(irq), 8'd0);
    check("pop_data", data, 8'h00);

    // Break and extended sequences
    send(8'h1C, 1'b0);
    send(8'hF0, 1'b0); send(8'h1C, 1'b0);
    send(8'hE0, 1'b0); send(8'h75, 1'b0);
    send(8'hE0, 1'b0); send(8'hF0, 1'b0); send(8'h75, 1'b0);
    check("seq_count", 8'(count), 8'd6);
    for (int i = 0; i < 6; i++) begin
      check($sformatf("seq_data%0d", i), data, exp_seq[i]);
      pop();
    end
    check("seq_empty", 8'(count), 8'd0);

    // Edge codes
    send(8'h83, 1'b0); check("code_83", data, 8'h41); pop();
    send(8'hFA, 1'b0); check("code_FA", data, 8'hFA); pop();
    send(8'h00, 1'b0); check("code_00", data, 8'hFF); pop();
    send(8'hE1, 1'b0); check("code_E1", data, 8'hE1); pop();
    send(8'h84, 1'b0); check("code_84_nopush", 8'(count), 8'd0);
    send(8'h02, 1'b0); check("code_02_nopush", 8'(count), 8'd0);
    send(8'hF0, 1'b0); send(8'h84, 1'b0); send(8'h1C, 1'b0);
    check("brk_cancel_84", data, 8'h1E);
    pop();

    // Overflow, then simultaneous push and pop while full
    repeat (DEPTH + 1) send(8'h1C, 1'b0);
    check("ovf_count", 8'(count), 8'd16);
    check("ovf_flag", 8'(overflow), 8'd1);
    check("ovf_irq", 8'(irq), 8'd1);
    send(8'h15, 1'b1);
    check("full_pp_count", 8'(count), 8'd16);
    check("full_pp_ovf", 8'(overflow), 8'd1);
    check("full_pp_head", data, 8'h1E);
    repeat (DEPTH - 1) pop();
    check("tail_data", data, 8'h10);
    check("tail_count", 8'(count), 8'd1);
    send(8'h1C, 1'b0); send(8'h1C, 1'b0);
    check("pre_clr_count", 8'(count), 8'd3);

    // clr beats a concurrent byte and pop, and cancels a pending break
    send(8'hF0, 1'b0);
    @(negedge clock);
    clr = 1'b1; kbd_done = 1'b1; kbd_data = 8'h1C; rd = 1'b1;
    @(negedge clock);
    clr = 1'b0; kbd_done = 1'b0; rd = 1'b0;
    check("clr_count", 8'(count), 8'd0);
    check("clr_irq", 8'(irq), 8'd0);
    check("clr_ovf", 8'(overflow), 8'd0);
    check("clr_data", data, 8'h00);
    send(8'h1C, 1'b0);
    check("clr_idle_make", data, 8'h1E);
    pop();

    // Asynchronous reset in the middle of a break sequence
    send(8'h1C, 1'b0);
    send(8'hF0, 1'b0);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("arst_count", 8'(count), 8'd0);
    check("arst_irq", 8'(irq), 8'd0);
    check("arst_data", data, 8'h00);
    @(negedge clock);
    reset = 1'b0;
    send(8'h1C, 1'b0);
    check("post_rst_count", 8'(count), 8'd1);
    check("post_rst_data", data, 8'h1E);
    check("post_rst_ovf", 8'(overflow), 8'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/kbd_set1_fifo.md
KBD_SET1_FIFO -- requirements
Module: kbd_set1_fifo

Interface
REQ-001 Parameter: DEPTH, 16, FIFO entries; power of two, 4..64.
REQ-002 clock  input  1  system clock; all state changes on posedge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 kbd_done  input  1  one-cycle strobe from PS/2 receiver: kbd_data holds a parity-valid set-2 byte.
REQ-005 kbd_data  input  8  received set-2 byte, sampled only when kbd_done=1.
REQ-006 rd  input  1  one-cycle pop strobe from CPU port-60h read; ignored when FIFO empty.
REQ-007 clr  input  1  synchronous flush: empties FIFO, clears overflow, returns FSM to IDLE.
REQ-008 data  output  8  FIFO head byte (set-1 code); 0x00 when empty.
REQ-009 irq  output  1  level, high while FIFO non-empty (IRQ1 request).
REQ-010 count  output  clog2(DEPTH)+1  current FIFO occupancy.
REQ-011 overflow  output  1  sticky; set when a push is dropped.

Function
REQ-012 FSM states: IDLE, BREAK; BREAK entered on byte 0xF0 from either state; no FIFO push for 0xF0.
REQ-013 Byte 0xE0 or 0xE1: push the same byte unchanged; state unchanged.
REQ-014 Bytes 0xFA, 0xAA, 0xEE, 0xFE: push unchanged; FSM forced to IDLE.
REQ-015 Bytes 0x00 and 0xFF (receiver overrun): push 0xFF; FSM forced to IDLE.
REQ-016 Any other byte <= 0x83: look up set-1 code; in IDLE push code, in BREAK push code|0x80 and return to IDLE.
REQ-017 Lookup result 0x00 (unmapped) or other byte > 0x83: no push; FSM returns to IDLE.
REQ-018 At most one push per kbd_done; push and state update occur on the same posedge that samples kbd_done=1.
REQ-019 count, irq, data reflect a push or pop from the following cycle (registered pointers/count).
REQ-020 Pop: rd=1 with count>0 advances read pointer; data then shows next entry.
REQ-021 Push with count=DEPTH and no concurrent pop: byte dropped, overflow<=1, contents unchanged.
REQ-022 Push and pop in same cycle: both performed, count unchanged, including when full (no overflow) or empty-then-push is not a simultaneous case (pop ignored when empty, push performed).
REQ-023 Pointers wrap modulo DEPTH; count never exceeds DEPTH.
REQ-024 clr has priority over kbd_done and rd in the same cycle; the incoming byte is discarded.

Reset
REQ-025 On reset: FSM IDLE, pointers 0, count 0, irq 0, overflow 0, data 0x00; takes effect immediately, independent of clock.
REQ-026 Reset mid-sequence (after 0xF0 or 0xE0) discards the pending prefix; next code byte is treated as a make.

Structure
REQ-027 Shared package holds: set-2 prefix/response constants (0xE0, 0xE1, 0xF0, 0xFA, 0xAA, 0xEE, 0xFE), break-bit mask 0x80, FSM state enum.
REQ-028 One sub-module kbd_set2to1: combinational 8-bit set-2 to set-1 lookup for indices 0x00..0x83, 0x00 for unmapped.
REQ-029 FIFO storage is a plain register array inside kbd_set1_fifo; no vendor RAM primitive.

Verification
REQ-030 Make: kbd_data 0x1C strobed -> next cycle count=1, irq=1, data=0x1E; rd pulse -> count=0, irq=0, data=0x00.
REQ-031 Break and extended: bytes 1C, F0 1C, E0 75, E0 F0 75 -> FIFO reads 1E, 9E, E0, 48, E0, C8 in order.
REQ-032 Edge codes: 0x83 -> 0x41; 0xFA -> 0xFA; 0x00 -> 0xFF; 0x84 -> no push, count unchanged.
REQ-033 Overflow: DEPTH+1 makes of 0x1C with no reads -> count=DEPTH, overflow=1, 17th dropped; then kbd_done with rd in same cycle -> count stays DEPTH, new byte at tail.
REQ-034 Reset mid-break: F0, assert reset, release, then 1C -> single entry 0x1E, overflow=0.
REQ-035 clr with simultaneous kbd_done (0x1C) and rd while count=3 -> next cycle count=0, irq=0, overflow=0, FSM IDLE.
